// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default widths, command codes,
// operand classes and the result/flag payload types.
package alu_pkg;

    localparam int unsigned ALU_WIDTH     = 8;
    localparam int unsigned ALU_CMD_WIDTH = 4;
    localparam int unsigned CODE_WIDTH    = 4;

    typedef enum logic [CODE_WIDTH-1:0] {
        ARITH_ADD     = 4'd0,
        ARITH_SUB     = 4'd1,
        ARITH_ADD_CIN = 4'd2,
        ARITH_SUB_CIN = 4'd3,
        ARITH_INC_A   = 4'd4,
        ARITH_DEC_A   = 4'd5,
        ARITH_INC_B   = 4'd6,
        ARITH_DEC_B   = 4'd7,
        ARITH_CMP     = 4'd8
    } arith_cmd_e;

    typedef enum logic [CODE_WIDTH-1:0] {
        LOGIC_AND    = 4'd0,
        LOGIC_NAND   = 4'd1,
        LOGIC_OR     = 4'd2,
        LOGIC_NOR    = 4'd3,
        LOGIC_XOR    = 4'd4,
        LOGIC_XNOR   = 4'd5,
        LOGIC_NOT_A  = 4'd6,
        LOGIC_NOT_B  = 4'd7,
        LOGIC_SHR1_A = 4'd8,
        LOGIC_SHL1_A = 4'd9,
        LOGIC_SHR1_B = 4'd10,
        LOGIC_SHL1_B = 4'd11,
        LOGIC_ROL    = 4'd12,
        LOGIC_ROR    = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        CLS_TWO     = 2'd0,
        CLS_A_ONLY  = 2'd1,
        CLS_B_ONLY  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

    typedef logic [ALU_WIDTH:0] alu_res_t;

    typedef struct packed {
        logic cout;
        logic oflow;
        logic e;
        logic g;
        logic l;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational command classifier: maps MODE/CMD to an operand class and
// flags illegal commands or operands that are not marked valid.
module alu_decode
    import alu_pkg::*;
#(
    parameter int unsigned CMD_WIDTH = ALU_CMD_WIDTH
) (
    input  logic                 i_mode,
    input  logic [CMD_WIDTH-1:0] i_cmd,
    input  logic [1:0]           i_inp_valid,
    output op_class_e            o_class_c,
    output logic                 o_err_c
);

    logic                  w_hi_set;
    logic [CODE_WIDTH-1:0] w_code;

    // Codes wider than the defined opcode space are always illegal.
    assign w_hi_set = |(i_cmd >> CODE_WIDTH);
    assign w_code   = CODE_WIDTH'(i_cmd);

    always_comb begin
        o_class_c = CLS_ILLEGAL;
        if (!w_hi_set) begin
            if (i_mode) begin
                case (w_code)
                    ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN,
                    ARITH_SUB_CIN, ARITH_CMP:         o_class_c = CLS_TWO;
                    ARITH_INC_A, ARITH_DEC_A:         o_class_c = CLS_A_ONLY;
                    ARITH_INC_B, ARITH_DEC_B:         o_class_c = CLS_B_ONLY;
                    default:                          o_class_c = CLS_ILLEGAL;
                endcase
            end else begin
                case (w_code)
                    LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR,
                    LOGIC_XOR, LOGIC_XNOR, LOGIC_ROL, LOGIC_ROR:
                                                      o_class_c = CLS_TWO;
                    LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A:
                                                      o_class_c = CLS_A_ONLY;
                    LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B:
                                                      o_class_c = CLS_B_ONLY;
                    default:                          o_class_c = CLS_ILLEGAL;
                endcase
            end
        end
    end

    always_comb begin
        o_err_c = 1'b1;
        case (o_class_c)
            CLS_TWO:    o_err_c = (i_inp_valid != 2'b11);
            CLS_A_ONLY: o_err_c = !i_inp_valid[0];
            CLS_B_ONLY: o_err_c = !i_inp_valid[1];
            default:    o_err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_modport.sv
// Registered ALU: decodes MODE/CMD each enabled cycle and registers the
// WIDTH+1 result together with carry, overflow, compare and error flags.
module alu_modport
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_WIDTH,
    parameter int unsigned CMD_WIDTH = ALU_CMD_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 MODE,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic [1:0]           INP_VALID,
    input  logic [WIDTH-1:0]     OPA,
    input  logic [WIDTH-1:0]     OPB,
    input  logic                 CIN,
    output logic [WIDTH:0]       RES,
    output logic                 COUT,
    output logic                 OFLOW,
    output logic                 E,
    output logic                 G,
    output logic                 L,
    output logic                 ERR
);

    localparam int unsigned RW = WIDTH + 1;

    op_class_e             w_class;
    logic                  w_opnd_err;
    logic [CODE_WIDTH-1:0] w_code;
    logic [WIDTH:0]        w_a;
    logic [WIDTH:0]        w_b;
    logic [WIDTH:0]        w_cin;
    logic [2:0]            w_amt;
    logic [WIDTH-1:0]      w_rol;
    logic [WIDTH-1:0]      w_ror;
    logic                  w_rot_err;
    logic [WIDTH:0]        w_res;
    alu_flags_t            w_flags;

    logic [WIDTH:0]        r_res;
    alu_flags_t            r_flags;

    alu_decode #(
        .CMD_WIDTH   (CMD_WIDTH)
    ) u_decode (
        .i_mode      (MODE),
        .i_cmd       (CMD),
        .i_inp_valid (INP_VALID),
        .o_class_c   (w_class),
        .o_err_c     (w_opnd_err)
    );

    assign w_code = CODE_WIDTH'(CMD);
    assign w_a    = {1'b0, OPA};
    assign w_b    = {1'b0, OPB};
    assign w_cin  = RW'(CIN);

    // Rotate amount uses OPB[2:0]; any higher-order OPB bit above bit 3 is an error.
    assign w_amt     = OPB[2:0];
    assign w_rol     = (OPA << w_amt) | (OPA >> (WIDTH - 32'(w_amt)));
    assign w_ror     = (OPA >> w_amt) | (OPA << (WIDTH - 32'(w_amt)));
    assign w_rot_err = |OPB[WIDTH-1:4];

    always_comb begin
        w_res   = '0;
        w_flags = '0;
        if (w_opnd_err) begin
            w_flags.err = 1'b1;
        end else if (MODE) begin
            case (w_code)
                ARITH_ADD: begin
                    w_res        = w_a + w_b;
                    w_flags.cout = w_res[WIDTH];
                end
                ARITH_ADD_CIN: begin
                    w_res        = w_a + w_b + w_cin;
                    w_flags.cout = w_res[WIDTH];
                end
                ARITH_SUB: begin
                    w_res         = w_a - w_b;
                    w_flags.oflow = (w_a < w_b);
                end
                ARITH_SUB_CIN: begin
                    w_res         = w_a - w_b - w_cin;
                    w_flags.oflow = (w_a < (w_b + w_cin));
                end
                ARITH_INC_A: begin
                    w_res         = w_a + RW'(1);
                    w_flags.oflow = &OPA;
                end
                ARITH_DEC_A: begin
                    w_res         = w_a - RW'(1);
                    w_flags.oflow = (OPA == '0);
                end
                ARITH_INC_B: begin
                    w_res         = w_b + RW'(1);
                    w_flags.oflow = &OPB;
                end
                ARITH_DEC_B: begin
                    w_res         = w_b - RW'(1);
                    w_flags.oflow = (OPB == '0);
                end
                ARITH_CMP: begin
                    w_flags.e = (OPA == OPB);
                    w_flags.g = (OPA > OPB);
                    w_flags.l = (OPA < OPB);
                end
                default: w_flags.err = 1'b1;
            endcase
        end else begin
            case (w_code)
                LOGIC_AND:    w_res = {1'b0, OPA & OPB};
                LOGIC_NAND:   w_res = {1'b0, ~(OPA & OPB)};
                LOGIC_OR:     w_res = {1'b0, OPA | OPB};
                LOGIC_NOR:    w_res = {1'b0, ~(OPA | OPB)};
                LOGIC_XOR:    w_res = {1'b0, OPA ^ OPB};
                LOGIC_XNOR:   w_res = {1'b0, ~(OPA ^ OPB)};
                LOGIC_NOT_A:  w_res = {1'b0, ~OPA};
                LOGIC_NOT_B:  w_res = {1'b0, ~OPB};
                LOGIC_SHR1_A: w_res = {1'b0, OPA >> 1};
                LOGIC_SHL1_A: w_res = {1'b0, OPA << 1};
                LOGIC_SHR1_B: w_res = {1'b0, OPB >> 1};
                LOGIC_SHL1_B: w_res = {1'b0, OPB << 1};
                LOGIC_ROL: begin
                    w_res       = {1'b0, w_rol};
                    w_flags.err = w_rot_err;
                end
                LOGIC_ROR: begin
                    w_res       = {1'b0, w_ror};
                    w_flags.err = w_rot_err;
                end
                default: w_flags.err = 1'b1;
            endcase
        end
    end

    // Output registers: reset wins over enable, CE=0 holds the last result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_res   <= '0;
            r_flags <= '0;
        end else if (CE) begin
            r_res   <= w_res;
            r_flags <= w_flags;
        end
    end

    assign RES   = r_res;
    assign COUT  = r_flags.cout;
    assign OFLOW = r_flags.oflow;
    assign E     = r_flags.e;
    assign G     = r_flags.g;
    assign L     = r_flags.l;
    assign ERR   = r_flags.err;

endmodule

// File: tb/tb_alu_modport.sv
// Testbench for alu_modport: directed cases plus randomized traffic checked
// against an integer-arithmetic reference model.
module tb_alu_modport;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] cmd = '0;
    logic [1:0] iv = '0;
    logic [7:0] opa = '0;
    logic [7:0] opb = '0;
    logic       cin = 1'b0;
    alu_res_t   res;
    logic       cout, oflow, e, g, l, err;

    int checks = 0;
    int errors = 0;
    int exp_res = 0;
    int exp_flags = 0;

    alu_modport #(.WIDTH(8), .CMD_WIDTH(4)) dut (
        .CLK(clk), .RST(rst), .CE(ce), .MODE(mode), .CMD(cmd),
        .INP_VALID(iv), .OPA(opa), .OPB(opb), .CIN(cin),
        .RES(res), .COUT(cout), .OFLOW(oflow), .E(e), .G(g), .L(l), .ERR(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Flags packed as {cout,oflow,e,g,l,err}.
    function automatic void model(input bit m, input int c, input int v, input int a,
                                  input int b, input int ci, output int r, output int f);
        int need;
        int co, ov, eq, gt, lt, er;
        r = 0; co = 0; ov = 0; eq = 0; gt = 0; lt = 0; er = 0;
        if (m) begin
            if (c <= 3 || c == 8) need = 3;
            else if (c == 4 || c == 5) need = 1;
            else if (c == 6 || c == 7) need = 2;
            else need = 0;
        end else begin
            if (c <= 5 || c == 12 || c == 13) need = 3;
            else if (c == 6 || c == 8 || c == 9) need = 1;
            else if (c == 7 || c == 10 || c == 11) need = 2;
            else need = 0;
        end
        if (need == 0 || (v & need) != need) begin
            er = 1;
        end else if (m) begin
            case (c)
                0: begin r = a + b;      co = (r >= 256); end
                2: begin r = a + b + ci; co = (r >= 256); end
                1: begin r = (a - b + 512) % 512;      ov = (a < b); end
                3: begin r = (a - b - ci + 512) % 512; ov = (a < b + ci); end
                4: begin r = a + 1; ov = (a == 255); end
                5: begin r = (a + 511) % 512; ov = (a == 0); end
                6: begin r = b + 1; ov = (b == 255); end
                7: begin r = (b + 511) % 512; ov = (b == 0); end
                default: begin eq = (a == b); gt = (a > b); lt = (a < b); end
            endcase
        end else begin
            case (c)
                0:  r = a & b;
                1:  r = 255 - (a & b);
                2:  r = a | b;
                3:  r = 255 - (a | b);
                4:  r = a ^ b;
                5:  r = 255 - (a ^ b);
                6:  r = 255 - a;
                7:  r = 255 - b;
                8:  r = a / 2;
                9:  r = (a * 2) % 256;
                10: r = b / 2;
                11: r = (b * 2) % 256;
                default: begin
                    r = a;
                    for (int k = 0; k < (b % 8); k++) begin
                        if (c == 12) r = ((r * 2) % 256) + (r / 128);
                        else         r = (r / 2) + ((r % 2) * 128);
                    end
                    er = (b >= 16);
                end
            endcase
        end
        f = co * 32 + ov * 16 + eq * 8 + gt * 4 + lt * 2 + er;
    endfunction

    task automatic step(input bit r_i, input bit ce_i, input bit m_i, input int c_i,
                        input int v_i, input int a_i, input int b_i, input bit ci_i,
                        input string tag);
        int mr, mf;
        rst = r_i; ce = ce_i; mode = m_i; cmd = 4'(c_i); iv = 2'(v_i);
        opa = 8'(a_i); opb = 8'(b_i); cin = ci_i;
        @(posedge clk);
        #1;
        if (r_i) begin
            exp_res = 0; exp_flags = 0;
        end else if (ce_i) begin
            model(m_i, c_i, v_i, a_i, b_i, int'(ci_i), mr, mf);
            exp_res = mr; exp_flags = mf;
        end
        check({tag, "_res"}, 32'(res), 32'(exp_res));
        check({tag, "_flags"}, 32'({cout, oflow, e, g, l, err}), 32'(exp_flags));
    endtask

    initial begin
        step(1, 1, 1, 0, 3, 'hAA, 'h55, 1, "reset");
        check("reset_lit", 32'({res, cout, oflow, e, g, l, err}), 32'h0);
        step(0, 0, 1, 0, 3, 'hFF, 'h01, 0, "ce0_after_reset");

        step(0, 1, 1, 0, 3, 'hFF, 'h01, 0, "add");
        check("add_lit", 32'({res, cout, err}), 32'({9'h100, 1'b1, 1'b0}));
        step(0, 1, 1, 2, 3, 'h10, 'h20, 1, "add_cin");
        check("add_cin_lit", 32'(res), 32'h031);
        step(0, 1, 1, 1, 3, 'h05, 'h07, 0, "sub");
        check("sub_lit", 32'({res, oflow}), 32'({9'h1FE, 1'b1}));
        step(0, 1, 1, 8, 3, 'h3C, 'h3C, 0, "cmp_eq");
        check("cmp_eq_lit", 32'({res, e, g, l}), 32'({9'h0, 3'b100}));
        step(0, 1, 1, 8, 3, 'h40, 'h3C, 0, "cmp_gt");
        step(0, 1, 1, 3, 3, 'h05, 'h05, 1, "sub_cin_borrow");
        step(0, 1, 1, 5, 1, 'h00, 'h00, 0, "dec_a_zero");
        check("dec_lit", 32'({res, oflow}), 32'({9'h1FF, 1'b1}));

        step(0, 1, 0, 0, 3, 'hF0, 'h3C, 0, "and");
        check("and_lit", 32'(res), 32'h030);
        step(0, 1, 0, 5, 3, 'hF0, 'h3C, 0, "xnor");
        check("xnor_lit", 32'(res), 32'h033);
        step(0, 1, 0, 12, 3, 'h81, 'h03, 0, "rol");
        check("rol_lit", 32'({res, err}), 32'({9'h00C, 1'b0}));
        step(0, 1, 0, 12, 3, 'h81, 'h13, 0, "rol_err");
        check("rol_err_lit", 32'(err), 32'h1);
        step(0, 1, 0, 13, 3, 'h81, 'h01, 0, "ror");
        step(0, 1, 0, 9, 1, 'h81, 'h00, 0, "shl1_a");

        step(0, 1, 1, 0, 1, 'h12, 'h34, 0, "add_iv01");
        check("add_iv01_lit", 32'({res, err}), 32'({9'h0, 1'b1}));
        step(0, 1, 1, 4, 1, 'hFF, 'h00, 0, "inc_a");
        check("inc_a_lit", 32'({res, oflow}), 32'({9'h100, 1'b1}));
        step(0, 1, 0, 15, 3, 'h12, 'h34, 0, "illegal");
        step(0, 1, 0, 6, 0, 'h12, 'h34, 0, "iv00");

        step(0, 1, 1, 0, 3, 'hFF, 'h01, 0, "hold_load");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 3, i + 1, 'h77, 1, "hold");
            check("hold_lit", 32'(res), 32'h100);
        end
        step(0, 1, 1, 0, 3, 'h01, 'h02, 0, "reenable");
        check("reenable_lit", 32'(res), 32'h003);

        for (int n = 0; n < 600; n++) begin
            int a, b, v;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 0 : 255;
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? 0 : 255;
            v = ($urandom_range(0, 3) != 0) ? 3 : int'($urandom_range(0, 3));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), v, a, b,
                 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
